// File: rtl/alu_rs_station_pkg.sv
// ---------------------------------------------------------------------------
// alu_rs_station_pkg
// Shared types for the ALU/CMP reservation station: operand source records,
// the full station entry, and the CDB broadcast record snooped for wake-up.
// No ports; imported by rs_entry_slot and alu_rs_station.
// ---------------------------------------------------------------------------
package alu_rs_station_pkg;

   localparam int XLEN             = 32;
   localparam int PHYS_REG_W       = 6;
   localparam int ROB_IDX_W        = 5;
   localparam int NUM_ALU_MULT_CDB = 3;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_SLL,
      ALU_SRL,
      ALU_SRA,
      CMP_SLT,
      CMP_SLTU,
      CMP_EQ
   } alu_op_t;

   typedef struct packed {
      logic                  rdy;
      logic [PHYS_REG_W-1:0] tag;
      logic [XLEN-1:0]       val;
   } rs_src_t;

   typedef struct packed {
      alu_op_t               ctrl;
      logic [PHYS_REG_W-1:0] rd_tag;
      logic [ROB_IDX_W-1:0]  rob_idx;
      rs_src_t               src1;
      rs_src_t               src2;
   } rs_entry_t;

   typedef struct packed {
      logic                  valid;
      logic [PHYS_REG_W-1:0] tag;
      logic [ROB_IDX_W-1:0]  rob_idx;
      logic [XLEN-1:0]       data;
   } cdb_t;

endpackage

// File: rtl/alu_rs_station_slot.sv
// ---------------------------------------------------------------------------
// rs_entry_slot
// One reservation-station entry: holds the op and both source operands and
// snoops every CDB to capture pending operands by tag. The same snoop is
// applied to incoming dispatch data so a result broadcast in the dispatch
// cycle is not lost.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         clears the entry's valid bit
//   write_en      load write_data into this (free) entry
//   write_data    dispatched op
//   clear         issue handshake on this entry; frees it
//   cdb           broadcast buses, lowest index wins on multiple hits
//   valid         entry holds an op
//   ready         entry holds an op with both sources ready
//   entry         registered entry contents
// ---------------------------------------------------------------------------
module rs_entry_slot
   import alu_rs_station_pkg::*;
#(
   parameter int NUM_CDB = NUM_ALU_MULT_CDB,
   parameter int TAG_W   = PHYS_REG_W
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     write_en,
   input  rs_entry_t                write_data,
   input  logic                     clear,
   input  cdb_t [NUM_CDB-1:0]       cdb,
   output logic                     valid,
   output logic                     ready,
   output rs_entry_t                entry
);

   rs_src_t   src1_woken;
   rs_src_t   src2_woken;
   rs_entry_t write_woken;
   logic      cdb_unused;

   // Capture a pending operand from the buses. Scanning from the top down
   // lets the lowest-numbered matching bus overwrite any higher one. A source
   // that is already ready is returned untouched.
   function automatic rs_src_t snoop(input rs_src_t src, input cdb_t [NUM_CDB-1:0] bus);
      rs_src_t res;
      res = src;
      if (!src.rdy) begin
         for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (bus[k].valid && (TAG_W'(bus[k].tag) == TAG_W'(src.tag))) begin
               res.rdy = 1'b1;
               res.val = bus[k].data;
            end
         end
      end
      return res;
   endfunction

   // Wake-up candidates for both the held entry and the dispatch bypass path.
   always_comb begin
      src1_woken       = snoop(entry.src1, cdb);
      src2_woken       = snoop(entry.src2, cdb);
      write_woken      = write_data;
      write_woken.src1 = snoop(write_data.src1, cdb);
      write_woken.src2 = snoop(write_data.src2, cdb);
   end

   // ROB indices on the buses are not needed for operand capture.
   always_comb begin
      cdb_unused = 1'b0;
      for (int k = 0; k < NUM_CDB; k++) begin
         cdb_unused = cdb_unused ^ (^cdb[k].rob_idx);
      end
   end

   // Entry state. The top only writes free slots and only clears valid ones,
   // so write_en and clear never meet on the same slot. Reset also zeroes the
   // payload so the issue mux presents all-zero after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         entry <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (write_en) begin
         valid <= 1'b1;
         entry <= write_woken;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (valid) begin
         entry.src1 <= src1_woken;
         entry.src2 <= src2_woken;
      end
   end

   assign ready = valid && entry.src1.rdy && entry.src2.rdy;

endmodule

// File: rtl/alu_rs_station.sv
// ---------------------------------------------------------------------------
// alu_rs_station
// ALU/CMP reservation station. Buffers dispatched ops whose operands may be
// pending, wakes them from CDB broadcasts, and issues one ready op per cycle
// over a valid/ready handshake.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         clears all entries (mispredict)
//   disp_valid    dispatch presenting disp_entry
//   disp_ready    at least one free entry (registered state only)
//   disp_entry    dispatched op
//   cdb           snooped broadcast buses
//   issue_valid   issue_entry holds a fully-ready op
//   issue_ready   FU accepts the op this cycle
//   issue_entry   lowest-index ready entry, zero when none
//   occupancy     number of valid entries
// ---------------------------------------------------------------------------
module alu_rs_station
   import alu_rs_station_pkg::*;
#(
   parameter int NUM_ENTRIES = 8,
   parameter int NUM_CDB     = NUM_ALU_MULT_CDB,
   parameter int TAG_W       = PHYS_REG_W,
   parameter int OCC_W       = $clog2(NUM_ENTRIES + 1)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  disp_valid,
   output logic                  disp_ready,
   input  rs_entry_t             disp_entry,
   input  cdb_t [NUM_CDB-1:0]    cdb,
   output logic                  issue_valid,
   input  logic                  issue_ready,
   output rs_entry_t             issue_entry,
   output logic [OCC_W-1:0]      occupancy
);

   localparam int IDX_W = $clog2(NUM_ENTRIES);

   logic [NUM_ENTRIES-1:0] slot_valid;
   logic [NUM_ENTRIES-1:0] slot_ready;
   logic [NUM_ENTRIES-1:0] slot_write;
   logic [NUM_ENTRIES-1:0] slot_clear;
   rs_entry_t              slot_entry [NUM_ENTRIES];

   logic                   free_found;
   logic [IDX_W-1:0]       free_idx;
   logic                   issue_found;
   logic [IDX_W-1:0]       issue_idx;
   logic                   accept;
   logic                   issue_fire;
   logic [OCC_W-1:0]       occ_q;

   // Lowest free index for dispatch and lowest ready index for issue. Both
   // look only at registered slot state, so a slot freed by this cycle's issue
   // is not offered to this cycle's dispatch.
   always_comb begin
      free_found  = 1'b0;
      free_idx    = '0;
      issue_found = 1'b0;
      issue_idx   = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (!slot_valid[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (slot_ready[i]) begin
            issue_found = 1'b1;
            issue_idx   = IDX_W'(i);
         end
      end
   end

   // Flush suppresses both handshakes as far as station state is concerned.
   assign accept     = disp_valid && free_found && !flush;
   assign issue_fire = issue_found && issue_ready && !flush;

   always_comb begin
      slot_write = '0;
      slot_clear = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         slot_write[i] = accept && (free_idx == IDX_W'(i));
         slot_clear[i] = issue_fire && (issue_idx == IDX_W'(i));
      end
   end

   for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_slot
      rs_entry_slot #(
         .NUM_CDB (NUM_CDB),
         .TAG_W   (TAG_W)
      ) u_slot (
         .clk        (clk),
         .rst        (rst),
         .flush      (flush),
         .write_en   (slot_write[g]),
         .write_data (disp_entry),
         .clear      (slot_clear[g]),
         .cdb        (cdb),
         .valid      (slot_valid[g]),
         .ready      (slot_ready[g]),
         .entry      (slot_entry[g])
      );
   end

   // Issue mux; drives zero when nothing is ready so the output is clean
   // after reset and flush.
   always_comb begin
      issue_entry = '0;
      if (issue_found) begin
         issue_entry = slot_entry[issue_idx];
      end
   end

   // Occupancy counter: dispatch and issue in the same cycle cancel out.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         occ_q <= '0;
      end else begin
         case ({accept, issue_fire})
            2'b10:   occ_q <= occ_q + OCC_W'(1);
            2'b01:   occ_q <= occ_q - OCC_W'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   assign disp_ready  = free_found;
   assign issue_valid = issue_found;
   assign occupancy   = occ_q;

endmodule

// File: tb/tb_alu_rs_station.sv
// ---------------------------------------------------------------------------
// tb_alu_rs_station
// Self-checking bench for alu_rs_station. Directed stimulus pushes expected
// issued entries into a queue; a monitor on the falling edge pops and compares
// on every issue handshake. Status outputs are checked directly.
// ---------------------------------------------------------------------------
module tb_alu_rs_station;
   import alu_rs_station_pkg::*;

   localparam int NE    = 8;
   localparam int NC    = NUM_ALU_MULT_CDB;
   localparam int OCC_W = $clog2(NE + 1);

   logic                clk;
   logic                rst;
   logic                flush;
   logic                disp_valid;
   logic                disp_ready;
   rs_entry_t           disp_entry;
   cdb_t [NC-1:0]       cdb;
   logic                issue_valid;
   logic                issue_ready;
   rs_entry_t           issue_entry;
   logic [OCC_W-1:0]    occupancy;

   int                  checks;
   int                  errors;
   rs_entry_t           exp_q [$];
   rs_entry_t           fill_e [NE];
   rs_entry_t           t5_e [6];
   rs_entry_t           e_tmp;

   alu_rs_station #(
      .NUM_ENTRIES (NE),
      .NUM_CDB     (NC),
      .TAG_W       (PHYS_REG_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .disp_valid  (disp_valid),
      .disp_ready  (disp_ready),
      .disp_entry  (disp_entry),
      .cdb         (cdb),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_entry (issue_entry),
      .occupancy   (occupancy)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop if the directed sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   function automatic rs_entry_t mk(input int rob, input int rd,
                                    input bit r1, input int t1, input logic [31:0] v1,
                                    input bit r2, input int t2, input logic [31:0] v2);
      rs_entry_t e;
      e.ctrl      = ALU_ADD;
      e.rd_tag    = PHYS_REG_W'(rd);
      e.rob_idx   = ROB_IDX_W'(rob);
      e.src1.rdy  = r1;
      e.src1.tag  = PHYS_REG_W'(t1);
      e.src1.val  = v1;
      e.src2.rdy  = r2;
      e.src2.tag  = PHYS_REG_W'(t2);
      e.src2.val  = v2;
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic dv, input rs_entry_t e);
      disp_valid = dv;
      disp_entry = e;
   endtask

   task automatic setCdb(input int k, input int tag, input logic [31:0] data);
      cdb[k].valid   = 1'b1;
      cdb[k].tag     = PHYS_REG_W'(tag);
      cdb[k].rob_idx = '0;
      cdb[k].data    = data;
   endtask

   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Scoreboard monitor: every accepted issue must match the next expected op.
   always @(negedge clk) begin
      if (!rst && !flush && issue_valid && issue_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_issue: got rob %0d expected none", issue_entry.rob_idx);
         end else begin
            e_tmp = exp_q.pop_front();
            if (issue_entry !== e_tmp) begin
               errors++;
               $display("[TB] FAIL issue_entry: got rob %0d s1 %0h s2 %0h expected rob %0d s1 %0h s2 %0h",
                        issue_entry.rob_idx, issue_entry.src1.val, issue_entry.src2.val,
                        e_tmp.rob_idx, e_tmp.src1.val, e_tmp.src2.val);
            end
         end
      end
   end

   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      flush       = 1'b0;
      issue_ready = 1'b0;
      cdb         = '0;
      applyStimulus(1'b0, '0);
      step();
      step();
      rst = 1'b0;

      $display("[TB] reset state");
      checkOutput("reset_disp_ready",  128'(disp_ready),  128'(1));
      checkOutput("reset_issue_valid", 128'(issue_valid), 128'(0));
      checkOutput("reset_occupancy",   128'(occupancy),   128'(0));
      checkOutput("reset_issue_entry", 128'(issue_entry), 128'(0));

      $display("[TB] test 1: ready dispatch issues next cycle");
      issue_ready = 1'b1;
      applyStimulus(1'b1, mk(1, 10, 1, 0, 32'd5, 1, 0, 32'd7));
      exp_q.push_back(mk(1, 10, 1, 0, 32'd5, 1, 0, 32'd7));
      step();
      applyStimulus(1'b0, '0);
      checkOutput("t1_occ_after_disp", 128'(occupancy),   128'(1));
      checkOutput("t1_issue_valid",    128'(issue_valid), 128'(1));
      step();
      checkOutput("t1_occ_after_issue", 128'(occupancy),   128'(0));
      checkOutput("t1_issue_idle",      128'(issue_valid), 128'(0));

      $display("[TB] test 2: CDB wake-up, issuable one cycle after capture");
      applyStimulus(1'b1, mk(2, 11, 0, 12, 32'd0, 1, 0, 32'd3));
      step();
      applyStimulus(1'b0, '0);
      checkOutput("t2_waiting", 128'(issue_valid), 128'(0));
      step();
      step();
      setCdb(1, 12, 32'hDEAD);
      checkOutput("t2_no_same_cycle_issue", 128'(issue_valid), 128'(0));
      exp_q.push_back(mk(2, 11, 1, 12, 32'hDEAD, 1, 0, 32'd3));
      step();
      cdb = '0;
      checkOutput("t2_issue_valid_after_capture", 128'(issue_valid), 128'(1));
      step();
      checkOutput("t2_occ", 128'(occupancy), 128'(0));

      $display("[TB] test 3: dispatch bypass from CDB");
      issue_ready = 1'b0;
      applyStimulus(1'b1, mk(3, 12, 1, 0, 32'd1, 0, 9, 32'd0));
      setCdb(0, 9, 32'h42);
      step();
      applyStimulus(1'b0, '0);
      cdb = '0;
      checkOutput("t3_issue_valid", 128'(issue_valid),        128'(1));
      checkOutput("t3_src2_rdy",    128'(issue_entry.src2.rdy), 128'(1));
      checkOutput("t3_src2_val",    128'(issue_entry.src2.val), 128'(32'h42));
      exp_q.push_back(mk(3, 12, 1, 0, 32'd1, 1, 9, 32'h42));
      issue_ready = 1'b1;
      step();
      checkOutput("t3_occ", 128'(occupancy), 128'(0));

      $display("[TB] test 4: full station, freed slot not reused same cycle");
      for (int i = 0; i < NE; i++) begin
         fill_e[i] = mk(i, i + 1, 0, 20 + i, 32'd0, 1, 0, 32'(i));
         applyStimulus(1'b1, fill_e[i]);
         step();
      end
      applyStimulus(1'b0, '0);
      checkOutput("t4_occ_full",        128'(occupancy),   128'(NE));
      checkOutput("t4_disp_ready_full", 128'(disp_ready),  128'(0));
      checkOutput("t4_none_ready",      128'(issue_valid), 128'(0));
      setCdb(0, 23, 32'h333);
      step();
      cdb = '0;
      e_tmp = fill_e[3];
      e_tmp.src1.rdy = 1'b1;
      e_tmp.src1.val = 32'h333;
      exp_q.push_back(e_tmp);
      applyStimulus(1'b1, mk(15, 30, 0, 40, 32'd0, 1, 0, 32'd15));
      checkOutput("t4_disp_ready_during_issue", 128'(disp_ready),  128'(0));
      checkOutput("t4_entry3_ready",            128'(issue_valid), 128'(1));
      step();
      checkOutput("t4_occ_after_issue",  128'(occupancy),  128'(NE - 1));
      checkOutput("t4_disp_ready_freed", 128'(disp_ready), 128'(1));
      step();
      applyStimulus(1'b0, '0);
      checkOutput("t4_occ_refilled", 128'(occupancy), 128'(NE));
      // Waking the new op and entry 4 together: slot 3 must win priority.
      setCdb(0, 40, 32'h400);
      setCdb(1, 24, 32'h240);
      exp_q.push_back(mk(15, 30, 1, 40, 32'h400, 1, 0, 32'd15));
      e_tmp = fill_e[4];
      e_tmp.src1.rdy = 1'b1;
      e_tmp.src1.val = 32'h240;
      exp_q.push_back(e_tmp);
      step();
      cdb = '0;
      checkOutput("t4_wake_issue_valid", 128'(issue_valid), 128'(1));
      step();
      step();
      checkOutput("t4_occ_six",    128'(occupancy),   128'(6));
      checkOutput("t4_issue_idle", 128'(issue_valid), 128'(0));

      $display("[TB] test 6: flush with dispatch, then reset with flush");
      flush = 1'b1;
      applyStimulus(1'b1, mk(20, 40, 1, 0, 32'd1, 1, 0, 32'd2));
      step();
      flush = 1'b0;
      applyStimulus(1'b0, '0);
      checkOutput("t6_flush_occ",         128'(occupancy),   128'(0));
      checkOutput("t6_flush_issue_valid", 128'(issue_valid), 128'(0));
      checkOutput("t6_flush_disp_ready",  128'(disp_ready),  128'(1));
      issue_ready = 1'b0;
      applyStimulus(1'b1, mk(21, 41, 1, 0, 32'd8, 1, 0, 32'd9));
      step();
      applyStimulus(1'b0, '0);
      checkOutput("t6_pre_rst_issue_valid", 128'(issue_valid), 128'(1));
      checkOutput("t6_pre_rst_occ",         128'(occupancy),   128'(1));
      rst   = 1'b1;
      flush = 1'b1;
      applyStimulus(1'b1, mk(22, 42, 1, 0, 32'd1, 1, 0, 32'd1));
      step();
      rst   = 1'b0;
      flush = 1'b0;
      applyStimulus(1'b0, '0);
      checkOutput("t6_rst_occ",         128'(occupancy),   128'(0));
      checkOutput("t6_rst_issue_valid", 128'(issue_valid), 128'(0));
      checkOutput("t6_rst_disp_ready",  128'(disp_ready),  128'(1));
      checkOutput("t6_rst_issue_entry", 128'(issue_entry), 128'(0));

      $display("[TB] test 5: issue held under backpressure, then in order");
      issue_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i == 2 || i == 5) begin
            t5_e[i] = mk(24 + i, 50 + i, 1, 0, 32'(100 + i), 1, 0, 32'(200 + i));
         end else begin
            t5_e[i] = mk(24 + i, 50 + i, 0, 50 + i, 32'd0, 1, 0, 32'(200 + i));
         end
         applyStimulus(1'b1, t5_e[i]);
         step();
      end
      applyStimulus(1'b0, '0);
      for (int c = 0; c < 4; c++) begin
         checkOutput("t5_held_entry", 128'(issue_entry), 128'(t5_e[2]));
         step();
      end
      exp_q.push_back(t5_e[2]);
      exp_q.push_back(t5_e[5]);
      issue_ready = 1'b1;
      step();
      checkOutput("t5_second_entry", 128'(issue_entry), 128'(t5_e[5]));
      checkOutput("t5_second_valid", 128'(issue_valid), 128'(1));
      step();
      checkOutput("t5_issue_idle", 128'(issue_valid), 128'(0));
      checkOutput("t5_occ",        128'(occupancy),   128'(4));
      issue_ready = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();

      checkOutput("scoreboard_drained", 128'(exp_q.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
